// File: rtl/io_map_pkg.sv
// Address map constants for the Hack memory-mapped I/O window.
// Shared by the bus controller and any future I/O decoders.
package io_map_pkg;

  localparam logic [14:0] IO_BASE_DEFAULT = 15'h6000;
  localparam int          WINDOW_WORDS    = 8;

  typedef enum logic [2:0] {
    OFF_LED   = 3'd0,
    OFF_DIR   = 3'd1,
    OFF_OUT   = 3'd2,
    OFF_IN    = 3'd3,
    OFF_EDGE  = 3'd4,
    OFF_TIMER = 3'd5,
    OFF_RSV6  = 3'd6,
    OFF_RSV7  = 3'd7
  } ioOffset_t;

  // Offsets 6 and 7 are holes in the map: they read 0 and ignore writes.
  function automatic logic isMappedOffset(input ioOffset_t off);
    return (off <= OFF_TIMER);
  endfunction

endpackage

// File: rtl/io_bus_ctrl_if.sv
// CPU-side data bus between the Hack CPU and the I/O controller.
// The CPU is the master; the I/O controller is the slave.
interface io_bus_ctrl_if;

  logic [14:0] addrIn;
  logic [15:0] dataIn;
  logic        writeEn;
  logic        readEn;
  logic        ioSel;
  logic [15:0] dataOut;

  modport master (
    output addrIn, dataIn, writeEn, readEn,
    input  ioSel, dataOut
  );

  modport slave (
    input  addrIn, dataIn, writeEn, readEn,
    output ioSel, dataOut
  );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with a history flop for rising-edge detection
// on an asynchronous input pin.
module sync_edge_det (
  input  logic CLK,
  input  logic RST,
  input  logic asyncIn,
  output logic syncOut,
  output logic rise
);

  logic metaFlop;
  logic prevSync;

  // History flop also resets to 0, so a pin held high through reset
  // still yields one rise once the synchroniser fills.
  always_ff @(posedge CLK) begin
    if (RST) begin
      metaFlop <= 1'b0;
      syncOut  <= 1'b0;
      prevSync <= 1'b0;
    end else begin
      metaFlop <= asyncIn;
      syncOut  <= metaFlop;
      prevSync <= syncOut;
    end
  end

  assign rise = syncOut & ~prevSync;

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O front end between the Hack CPU bus and ioports:
// register decode, load pulses, GPIO edge capture and a millisecond timer.
module io_bus_ctrl
  import io_map_pkg::*;
#(
  parameter logic [14:0] IO_BASE = IO_BASE_DEFAULT,
  parameter int          CLK_HZ  = 16000000,
  parameter int          TICK_HZ = 1000
) (
  input  logic         CLK,
  input  logic         RST,
  io_bus_ctrl_if.slave bus,
  output logic         ioData,
  output logic         ledLoad,
  output logic         gpioDir,
  output logic         gpioLoad,
  input  logic         gpioIn
);

  localparam int PRESCALE_DIV = CLK_HZ / TICK_HZ;
  localparam int PW           = $clog2(PRESCALE_DIV);
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(PRESCALE_DIV - 1);

  logic          hit;
  ioOffset_t     offset;
  logic          mapped;
  logic          wrHit;
  logic          rdHit;
  logic [15:0]   readValue;

  logic          ledReg;
  logic          dirReg;
  logic          outReg;
  logic          edgeFlag;
  logic [15:0]   timer;
  logic [PW-1:0] prescaler;

  logic          pinSync;
  logic          pinRise;

  // The window is 8-word aligned, so the low address bits are the offset.
  assign hit    = (bus.addrIn[14:3] == IO_BASE[14:3]);
  assign offset = ioOffset_t'(bus.addrIn[2:0]);
  assign mapped = hit && isMappedOffset(offset);
  assign wrHit  = bus.writeEn && hit;
  assign rdHit  = bus.readEn && hit;

  sync_edge_det pinSyncInst (
    .CLK     (CLK),
    .RST     (RST),
    .asyncIn (gpioIn),
    .syncOut (pinSync),
    .rise    (pinRise)
  );

  always_comb begin
    readValue = '0;
    if (hit) begin
      case (offset)
        OFF_LED:   readValue = {15'b0, ledReg};
        OFF_DIR:   readValue = {15'b0, dirReg};
        OFF_OUT:   readValue = {15'b0, outReg};
        OFF_IN:    readValue = {15'b0, pinSync};
        OFF_EDGE:  readValue = {15'b0, edgeFlag};
        OFF_TIMER: readValue = timer;
        default:   readValue = '0;
      endcase
    end
  end

  // Read data is sampled from current register values, so a read and a
  // write to the same register in one cycle returns the pre-write value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.ioSel   <= 1'b0;
      bus.dataOut <= '0;
      ioData      <= 1'b0;
      ledLoad     <= 1'b0;
      gpioDir     <= 1'b0;
      gpioLoad    <= 1'b0;
      ledReg      <= 1'b0;
      dirReg      <= 1'b0;
      outReg      <= 1'b0;
      edgeFlag    <= 1'b0;
      timer       <= '0;
      prescaler   <= '0;
    end else begin
      ledLoad   <= 1'b0;
      gpioDir   <= 1'b0;
      gpioLoad  <= 1'b0;
      bus.ioSel <= mapped;

      if (bus.readEn) begin
        bus.dataOut <= readValue;
      end

      if (wrHit) begin
        case (offset)
          OFF_LED: begin
            ledReg  <= bus.dataIn[0];
            ioData  <= bus.dataIn[0];
            ledLoad <= 1'b1;
          end
          OFF_DIR: begin
            dirReg  <= bus.dataIn[0];
            ioData  <= bus.dataIn[0];
            gpioDir <= 1'b1;
          end
          OFF_OUT: begin
            outReg   <= bus.dataIn[0];
            ioData   <= bus.dataIn[0];
            gpioLoad <= 1'b1;
          end
          default: ;
        endcase
      end

      // A new edge outranks the clearing read so no event is lost.
      if (pinRise) begin
        edgeFlag <= 1'b1;
      end else if (rdHit && offset == OFF_EDGE) begin
        edgeFlag <= 1'b0;
      end

      // A CPU load of the timer outranks the tick and restarts the millisecond.
      if (wrHit && offset == OFF_TIMER) begin
        timer     <= bus.dataIn;
        prescaler <= '0;
      end else if (prescaler == PRESCALE_MAX) begin
        prescaler <= '0;
        timer     <= timer + 16'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed self-checking bench for io_bus_ctrl: register map, load pulses,
// GPIO synchroniser/edge flag, timer wrap and reset behaviour.
module tb_io_bus_ctrl;

  logic CLK;
  logic RST;
  logic ioData;
  logic ledLoad;
  logic gpioDir;
  logic gpioLoad;
  logic gpioIn;

  int assertCount;
  int failCount;

  io_bus_ctrl_if cpuBus ();

  io_bus_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (cpuBus.slave),
    .ioData   (ioData),
    .ledLoad  (ledLoad),
    .gpioDir  (gpioDir),
    .gpioLoad (gpioLoad),
    .gpioIn   (gpioIn)
  );

  initial CLK = 1'b0;
  always #31.25 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one bus cycle, then returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic [14:0] addr, input logic [15:0] data,
                               input logic we, input logic re);
    cpuBus.addrIn  = addr;
    cpuBus.dataIn  = data;
    cpuBus.writeEn = we;
    cpuBus.readEn  = re;
    @(posedge CLK);
    #1;
    cpuBus.writeEn = 1'b0;
    cpuBus.readEn  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic checkNoPulses(input string tag);
    checkOutput({tag, "_ledLoad"},  ledLoad,  1'b0);
    checkOutput({tag, "_gpioDir"},  gpioDir,  1'b0);
    checkOutput({tag, "_gpioLoad"}, gpioLoad, 1'b0);
  endtask

  initial begin
    assertCount    = 0;
    failCount      = 0;
    RST            = 1'b1;
    gpioIn         = 1'b0;
    cpuBus.addrIn  = '0;
    cpuBus.dataIn  = '0;
    cpuBus.writeEn = 1'b0;
    cpuBus.readEn  = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    checkOutput("rst_ioSel",   cpuBus.ioSel,   1'b0);
    checkOutput("rst_dataOut", cpuBus.dataOut, 16'h0000);
    checkOutput("rst_ioData",  ioData,         1'b0);
    checkNoPulses("rst");

    // LED write, single-cycle pulse, readback
    applyStimulus(15'h6000, 16'h0001, 1'b1, 1'b0);
    checkOutput("led_ledLoad", ledLoad, 1'b1);
    checkOutput("led_ioData",  ioData,  1'b1);
    checkOutput("led_gpioDir", gpioDir, 1'b0);
    checkOutput("led_gpioLoad", gpioLoad, 1'b0);
    checkOutput("led_ioSel",   cpuBus.ioSel, 1'b1);
    idle(1);
    checkOutput("led_pulseEnd", ledLoad, 1'b0);
    applyStimulus(15'h6000, 16'h0000, 1'b0, 1'b1);
    checkOutput("led_read", cpuBus.dataOut, 16'h0001);
    idle(2);
    checkOutput("led_hold", cpuBus.dataOut, 16'h0001);

    // Back-to-back DIR then OUT writes
    applyStimulus(15'h6001, 16'h0001, 1'b1, 1'b0);
    checkOutput("dir_gpioDir",  gpioDir,  1'b1);
    checkOutput("dir_gpioLoad", gpioLoad, 1'b0);
    checkOutput("dir_ledLoad",  ledLoad,  1'b0);
    checkOutput("dir_ioData",   ioData,   1'b1);
    applyStimulus(15'h6002, 16'h0000, 1'b1, 1'b0);
    checkOutput("out_gpioLoad", gpioLoad, 1'b1);
    checkOutput("out_gpioDir",  gpioDir,  1'b0);
    checkOutput("out_ledLoad",  ledLoad,  1'b0);
    checkOutput("out_ioData",   ioData,   1'b0);
    idle(1);
    checkNoPulses("b2b_end");
    applyStimulus(15'h6001, 16'h0000, 1'b0, 1'b1);
    checkOutput("dir_read", cpuBus.dataOut, 16'h0001);
    applyStimulus(15'h6002, 16'h0000, 1'b0, 1'b1);
    checkOutput("out_read", cpuBus.dataOut, 16'h0000);

    // GPIO synchroniser latency and edge flag read-to-clear
    gpioIn = 1'b1;
    applyStimulus(15'h6003, 16'h0000, 1'b0, 1'b1);
    checkOutput("in_lat1", cpuBus.dataOut, 16'h0000);
    applyStimulus(15'h6003, 16'h0000, 1'b0, 1'b1);
    checkOutput("in_lat2", cpuBus.dataOut, 16'h0000);
    applyStimulus(15'h6003, 16'h0000, 1'b0, 1'b1);
    checkOutput("in_high", cpuBus.dataOut, 16'h0001);
    applyStimulus(15'h6004, 16'h0000, 1'b0, 1'b1);
    checkOutput("edge_set", cpuBus.dataOut, 16'h0001);
    applyStimulus(15'h6004, 16'h0000, 1'b0, 1'b1);
    checkOutput("edge_clr", cpuBus.dataOut, 16'h0000);

    // Edge coinciding with the clearing read keeps the flag set
    gpioIn = 1'b0;
    idle(4);
    gpioIn = 1'b1;
    idle(3);
    gpioIn = 1'b0;
    idle(4);
    gpioIn = 1'b1;
    idle(2);
    applyStimulus(15'h6004, 16'h0000, 1'b0, 1'b1);
    checkOutput("edge_coinc1", cpuBus.dataOut, 16'h0001);
    applyStimulus(15'h6004, 16'h0000, 1'b0, 1'b1);
    checkOutput("edge_coinc2", cpuBus.dataOut, 16'h0001);
    applyStimulus(15'h6004, 16'h0000, 1'b0, 1'b1);
    checkOutput("edge_coinc3", cpuBus.dataOut, 16'h0000);

    // Timer load, wrap and tick
    applyStimulus(15'h6005, 16'hFFFF, 1'b1, 1'b0);
    checkNoPulses("tmr_wr");
    applyStimulus(15'h6005, 16'h0000, 1'b0, 1'b1);
    checkOutput("tmr_load", cpuBus.dataOut, 16'hFFFF);
    idle(15999);
    applyStimulus(15'h6005, 16'h0000, 1'b0, 1'b1);
    checkOutput("tmr_wrap", cpuBus.dataOut, 16'h0000);
    idle(15999);
    applyStimulus(15'h6005, 16'h0000, 1'b0, 1'b1);
    checkOutput("tmr_tick", cpuBus.dataOut, 16'h0001);

    // Reserved and out-of-window accesses
    applyStimulus(15'h6007, 16'h0001, 1'b1, 1'b0);
    checkNoPulses("rsv_wr");
    checkOutput("rsv_wr_ioSel", cpuBus.ioSel, 1'b0);
    applyStimulus(15'h6007, 16'h0000, 1'b0, 1'b1);
    checkOutput("rsv_rd", cpuBus.dataOut, 16'h0000);
    checkOutput("rsv_rd_ioSel", cpuBus.ioSel, 1'b0);
    applyStimulus(15'h6000, 16'h0000, 1'b0, 1'b1);
    checkOutput("led_reread", cpuBus.dataOut, 16'h0001);
    applyStimulus(15'h5FFF, 16'h0001, 1'b1, 1'b0);
    checkNoPulses("miss_wr");
    applyStimulus(15'h5FFF, 16'h0000, 1'b0, 1'b1);
    checkOutput("miss_rd", cpuBus.dataOut, 16'h0000);
    checkOutput("miss_ioSel", cpuBus.ioSel, 1'b0);

    // Simultaneous read and write returns the old value
    applyStimulus(15'h6000, 16'h0000, 1'b1, 1'b1);
    checkOutput("rw_old", cpuBus.dataOut, 16'h0001);
    checkOutput("rw_ledLoad", ledLoad, 1'b1);
    applyStimulus(15'h6000, 16'h0000, 1'b0, 1'b1);
    checkOutput("rw_new", cpuBus.dataOut, 16'h0000);

    // Reset asserted during a write cycle
    applyStimulus(15'h6000, 16'h0001, 1'b1, 1'b0);
    applyStimulus(15'h6000, 16'h0000, 1'b0, 1'b1);
    checkOutput("pre_rst_read", cpuBus.dataOut, 16'h0001);
    RST = 1'b1;
    applyStimulus(15'h6000, 16'h0001, 1'b1, 1'b0);
    checkOutput("rstw_ledLoad", ledLoad, 1'b0);
    checkOutput("rstw_dataOut", cpuBus.dataOut, 16'h0000);
    RST = 1'b0;
    idle(1);
    checkOutput("rstw_after", ledLoad, 1'b0);
    applyStimulus(15'h6000, 16'h0000, 1'b0, 1'b1);
    checkOutput("rstw_read", cpuBus.dataOut, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/io_bus_ctrl.md
Name: io_bus_ctrl

Overview:
- Memory-mapped I/O front end between the Hack CPU data bus and the ioports block.
- Decodes CPU address/write strobes into the single-bit load pulses and data bit that ioports consumes.
- Synchronises and edge-detects the GPIO input ioports returns, and provides a millisecond tick timer.
- Returns registered read data to the CPU.

Parameters:
- IO_BASE, 15'h6000, base word address of the 8-word I/O window.
- CLK_HZ, 16000000, clock frequency used to derive the 1 ms tick.
- TICK_HZ, 1000, timer increment rate.

Ports:
- CLK  in  1  system clock, 16 MHz.
- RST  in  1  synchronous reset, active-high.
- addrIn  in  15  CPU word address.
- dataIn  in  16  CPU write data.
- writeEn  in  1  CPU write strobe.
- readEn  in  1  CPU read strobe.
- ioSel  out  1  registered: the previous-cycle address hit the I/O window.
- dataOut  out  16  registered read data to CPU.
- ioData  out  1  data bit driven to ioports dataIn.
- ledLoad  out  1  load pulse to ioports.
- gpioDir  out  1  direction-load pulse to ioports.
- gpioLoad  out  1  output-data load pulse to ioports.
- gpioIn  in  1  ioports dataOut (raw pin, asynchronous).

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- Reset values: all outputs 0; shadow regs (led, dir, out) 0; edge flag 0; sync flops 0; prescaler 0; timer 0.
- Register map (offset = addrIn - IO_BASE; hit only when addrIn[14:3] == IO_BASE[14:3]):
  - 0 LED: R/W shadow.
  - 1 DIR: R/W shadow.
  - 2 OUT: R/W shadow.
  - 3 IN: RO, synced pin.
  - 4 EDGE: RO, read-to-clear.
  - 5 TIMER: R/W.
  - 6-7: reserved; read 0, writes ignored.
- Write path:
  - writeEn && hit at cycle N: shadow reg updated at N+1.
  - ioData = dataIn[0], registered at N+1.
  - Exactly one of ledLoad/gpioDir/gpioLoad is high for the single cycle N+1, so ioports latches at the N+1 edge.
  - Consecutive writes on back-to-back cycles each produce their own pulse; no merging.
- Read path:
  - readEn at cycle N: dataOut valid at N+1, bit0 = register value, bits 15:1 = 0 except TIMER (full 16 bits).
  - dataOut holds until the next readEn.
  - Miss or reserved address: dataOut = 0 and ioSel = 0.
- Simultaneous read and write to the same register in one cycle: read returns the pre-write value.
- GPIO input:
  - Two-flop synchroniser, then one history flop.
  - Rising edge (sync=1, prev=0) sets the EDGE flag.
  - A read of EDGE returns the flag and clears it at N+1.
  - If an edge and the clearing read coincide, set wins and the flag stays 1.
  - Pin high through reset sets the flag 3 cycles after RST deasserts (history resets to 0).
- Timer:
  - Prescaler counts 0..CLK_HZ/TICK_HZ-1 (15999), then wraps; timer increments on wrap.
  - Timer is 16-bit and wraps 0xFFFF -> 0x0000.
  - Write to TIMER loads dataIn and clears the prescaler; that write beats a coincident increment.
- Reset mid-operation: pending pulses and dataOut drop to 0 on the next edge; no load pulse is emitted in the reset cycle or the cycle after.

Decomposition:
- io_map_pkg: IO_BASE default, offset constants (OFF_LED=0, OFF_DIR=1, OFF_OUT=2, OFF_IN=3, OFF_EDGE=4, OFF_TIMER=5), window size 8.
- Sub-module sync_edge_det (CLK, RST, async in, synced out, rise pulse), reusable for future input pins.
- Timer and decode stay in io_bus_ctrl.

Test Plan:
- Reset with gpioIn=0: all outputs 0. Then write 0x0001 to 0x6000: ledLoad=1 and ioData=1 for exactly one cycle, then a read of 0x6000 returns 0x0001.
- Writes to 0x6001, then 0x6002 on back-to-back cycles: gpioDir pulse, then gpioLoad pulse on consecutive cycles; no overlap; ledLoad stays 0.
- gpioIn 0->1: reading 0x6003 returns 1 no earlier than 2 cycles later. Reading 0x6004 returns 1, then 0 on the next read. An edge injected in the clearing-read cycle leaves the flag at 1.
- Write 0xFFFF to 0x6005 and run 16000 cycles: read returns 0x0000 (wrap). After another 16000 cycles, read returns 0x0001.
- Write and read to 0x6007 and 0x5FFF: no load pulses, dataOut=0, ioSel=0.
- Assert RST during a write cycle to 0x6000: no ledLoad pulse; a later read of 0x6000 returns 0.
